// File: rtl/aoi_response_checker.sv
// rtl/aoi_response_checker.sv - exhaustive 16-vector response checker for an AOI circuit (e=a&b, f=c&d, g=~(e|f))
module aoi_response_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_e,
    input  logic       dut_f,
    input  logic       dut_g,
    output logic [3:0] stim,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic [2:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    // Settle counter runs 0..SETTLE-1 so each vector occupies SETTLE+1 cycles including SAMPLE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [2:0] golden;
    logic [2:0] diff;
    logic       mismatch;
    logic [4:0] err_next;

    always_comb begin
        golden[2] = stim[3] & stim[2];
        golden[1] = stim[1] & stim[0];
        golden[0] = ~(golden[2] | golden[1]);
        diff      = golden ^ {dut_e, dut_f, dut_g};
        mismatch  = |diff;
        err_next  = err_count + 5'(mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stim       <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_mask  <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        fail_mask <= fail_mask | diff;
                        if (err_count == 5'd0) begin
                            first_fail <= stim;
                        end
                    end
                    settle_cnt <= '0;
                    // Last vector: stim stays at 15 so the final vector remains visible after the run.
                    if (stim == 4'd15) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        stim  <= stim + 4'd1;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aoi_response_checker.sv
// tb/tb_aoi_response_checker.sv - randomized self-checking bench for aoi_response_checker (SETTLE=2 and SETTLE=1)
module tb_aoi_response_checker;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [3:0] stim_a, stim_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [4:0] err_a, err_b;
    logic [3:0] ff_a, ff_b;
    logic [2:0] mask_a, mask_b;
    logic [2:0] resp_a, resp_b;

    logic [2:0] xor_tab [16];
    logic [2:0] and_mask;
    bit         sel;
    int         checks;
    int         failures;

    function automatic logic [2:0] aoi(input logic [3:0] v);
        logic e, f;
        e = v[3] & v[2];
        f = v[1] & v[0];
        return {e, f, ~(e | f)};
    endfunction

    // Faulty circuit under test: per-output stuck-at-0 plus per-vector flips.
    assign resp_a = (aoi(stim_a) & and_mask) ^ xor_tab[stim_a];
    assign resp_b = (aoi(stim_b) & and_mask) ^ xor_tab[stim_b];

    aoi_response_checker #(.SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .dut_e(resp_a[2]), .dut_f(resp_a[1]), .dut_g(resp_a[0]),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a), .fail_mask(mask_a)
    );

    aoi_response_checker #(.SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .dut_e(resp_b[2]), .dut_f(resp_b[1]), .dut_g(resp_b[0]),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b), .fail_mask(mask_b)
    );

    logic [3:0] o_stim, o_ff;
    logic       o_busy, o_done, o_pass;
    logic [4:0] o_err;
    logic [2:0] o_mask;

    assign o_stim = sel ? stim_b : stim_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_pass = sel ? pass_b : pass_a;
    assign o_err  = sel ? err_b  : err_a;
    assign o_ff   = sel ? ff_b   : ff_a;
    assign o_mask = sel ? mask_b : mask_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input bit v);
        if (sel) start_b = v;
        else start_a = v;
    endtask

    task automatic set_clean();
        and_mask = 3'b111;
        for (int v = 0; v < 16; v++) xor_tab[v] = 3'b000;
    endtask

    task automatic set_random(input int pct);
        and_mask = 3'b111;
        for (int v = 0; v < 16; v++)
            xor_tab[v] = ($urandom_range(99) < pct) ? 3'($urandom_range(7, 1)) : 3'b000;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stim"}, 32'(o_stim), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_pass"}, 32'(o_pass), 0);
        check({tag, "_err"},  32'(o_err),  0);
        check({tag, "_ff"},   32'(o_ff),   0);
        check({tag, "_mask"}, 32'(o_mask), 0);
    endtask

    // Full run from IDLE/DONE; rep_at >= 0 re-pulses start at that cycle of the run.
    task automatic run_check(input string tag, input int rep_at);
        int         s, len, e_err;
        logic [3:0] e_ff;
        logic [2:0] e_mask, d;
        bit         stim_ok, busy_ok, done_ok;
        s      = sel ? 1 : 2;
        len    = 16 * (s + 1);
        e_err  = 0;
        e_ff   = 4'd0;
        e_mask = 3'b000;
        for (int v = 0; v < 16; v++) begin
            d = ((aoi(4'(v)) & and_mask) ^ xor_tab[v]) ^ aoi(4'(v));
            if (d != 3'b000) begin
                if (e_err == 0) e_ff = 4'(v);
                e_err++;
                e_mask |= d;
            end
        end
        @(negedge clk);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        check({tag, "_clr_err"},  32'(o_err),  0);
        check({tag, "_clr_mask"}, 32'(o_mask), 0);
        check({tag, "_clr_ff"},   32'(o_ff),   0);
        stim_ok = 1'b1;
        busy_ok = 1'b1;
        done_ok = 1'b1;
        for (int c = 0; c < len; c++) begin
            if (o_stim !== 4'(c / (s + 1))) stim_ok = 1'b0;
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (o_done !== 1'b0 || o_pass !== 1'b0) done_ok = 1'b0;
            drive_start(c == rep_at);
            @(negedge clk);
        end
        drive_start(1'b0);
        check({tag, "_stim_seq"},  32'(stim_ok), 1);
        check({tag, "_busy_run"},  32'(busy_ok), 1);
        check({tag, "_done_run"},  32'(done_ok), 1);
        check({tag, "_done"},      32'(o_done),  1);
        check({tag, "_busy_end"},  32'(o_busy),  0);
        check({tag, "_stim_end"},  32'(o_stim),  15);
        check({tag, "_err"},       32'(o_err),   32'(e_err));
        check({tag, "_first"},     32'(o_ff),    32'(e_ff));
        check({tag, "_mask"},      32'(o_mask),  32'(e_mask));
        check({tag, "_pass"},      32'(o_pass),  32'(e_err == 0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rst_n    = 1'b0;
        set_clean();
        repeat (3) @(negedge clk);
        check_idle("rst_a");
        sel = 1'b1;
        check_idle("rst_b");
        sel = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("post_rst_a");

        run_check("clean_s2", -1);

        and_mask = 3'b110;
        run_check("g_stuck0", -1);
        and_mask = 3'b011;
        run_check("e_stuck0", -1);

        for (int i = 0; i < 6; i++) begin
            set_random(i * 15);
            run_check("rand_s2", -1);
        end

        set_clean();
        run_check("repulse", 10);
        set_random(30);
        run_check("restart_done", -1);

        // Abort mid-run with a nonzero partial result pending.
        set_clean();
        xor_tab[0] = 3'b101;
        xor_tab[3] = 3'b010;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_err_nonzero", 32'(o_err != 5'd0), 1);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_idle("after_release");

        sel = 1'b1;
        set_clean();
        run_check("clean_s1", -1);
        for (int i = 0; i < 4; i++) begin
            set_random(20 + i * 20);
            run_check("rand_s1", -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aoi_response_checker.md
AOI_RESPONSE_CHECKER -- requirements
Module: aoi_response_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, legal range 1..15: number of wait cycles between driving a vector and sampling the DUT outputs.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port start  input  1  single-cycle request to run a full exhaustive check.
REQ-005 Port dut_e, dut_f, dut_g  input  1 each  outputs returned by the AOI circuit under test.
REQ-006 Port stim  output  4  vector driven to the circuit under test: stim[3]=a, stim[2]=b, stim[1]=c, stim[0]=d.
REQ-007 Port busy  output  1  high while a check run is in progress.
REQ-008 Port done  output  1  high from run completion until the next accepted start or reset.
REQ-009 Port pass  output  1  valid while done=1: 1 when err_count=0.
REQ-010 Port err_count  output  5  number of mismatching vectors in the current or last run, 0..16.
REQ-011 Port first_fail  output  4  index of the first mismatching vector; 0 when no mismatch has occurred.
REQ-012 Port fail_mask  output  3  sticky per-output mismatch flags: {e,f,g} = bits [2:0].

Function
REQ-013 Golden model SHALL be e=a&b, f=c&d, g=~(e|f), evaluated on the registered stim value.
REQ-014 FSM states SHALL be IDLE, WAIT, SAMPLE, DONE.
REQ-015 IDLE or DONE with start=1: next cycle SHALL set stim=0, clear err_count, first_fail and fail_mask, clear done, set busy, load settle counter to 0, and enter WAIT.
REQ-016 WAIT SHALL hold stim stable for exactly SETTLE cycles, then enter SAMPLE.
REQ-017 SAMPLE (one cycle) SHALL compare {dut_e,dut_f,dut_g} against golden outputs.
REQ-018 On a mismatch in SAMPLE, err_count SHALL increment by 1.
REQ-019 On a mismatch in SAMPLE, the mismatching bits SHALL be OR-ed into fail_mask.
REQ-020 On a mismatch in SAMPLE, first_fail SHALL capture stim only if err_count was 0 before that sample.
REQ-021 SAMPLE with stim<15 SHALL increment stim and return to WAIT.
REQ-022 SAMPLE with stim=15 SHALL enter DONE with busy=0, done=1, and stim held at 15 (no wrap).
REQ-023 Run latency from the start-accept edge to done=1 SHALL be exactly 16*(SETTLE+1) cycles; this is 48 cycles for SETTLE=2.
REQ-024 start asserted while busy=1 SHALL be ignored, with no restart and no counter change.
REQ-025 start held high continuously SHALL be treated as one request per IDLE/DONE visit.
REQ-026 pass SHALL equal (err_count==0) & done and SHALL be 0 whenever done=0.
REQ-027 All outputs SHALL be registered; the dut_* inputs SHALL be sampled only in SAMPLE and ignored in all other states.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, and fail_mask=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-030 After rst_n deasserts, a new start SHALL be required before any run begins.

Verification
REQ-031 Bench with a correct AOI model, SETTLE=2: pulse start -> busy for 48 cycles, stim steps 0..15 every 3 cycles; done=1, pass=1, err_count=0, fail_mask=000.
REQ-032 dut_g stuck at 0 -> done with err_count=9, first_fail=0, fail_mask=001, pass=0.
REQ-033 dut_e stuck at 0 -> err_count=4 (vectors 12..15), first_fail=12, fail_mask=100.
REQ-034 start re-pulsed at cycle 10 of a run -> ignored, done still at cycle 48; start pulsed in DONE -> counters cleared and a new 48-cycle run begins.
REQ-035 rst_n pulled low at cycle 20 of a run -> all outputs 0 within the same cycle; after release, outputs stay idle until the next start.
REQ-036 SETTLE=1 with a correct model -> done after exactly 32 cycles, pass=1.
